// File: rtl/mru_tracker.sv
// mru_tracker: rank-ordered most-recently-used tracker for N_CH buttons with MRU/LRU eviction when full.
module mru_tracker #(
  parameter int N_CH     = 5,
  parameter int TICK_DIV = 100000000,
  parameter int MODE     = 0,
  parameter int IDX_W    = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  btn,
  input  logic             clr,
  output logic [N_CH-1:0]  led_free,
  output logic [IDX_W:0]   occ_count,
  output logic [IDX_W-1:0] mru_idx,
  output logic [IDX_W-1:0] lru_idx,
  output logic             evict_valid,
  output logic [IDX_W-1:0] evict_idx,
  output logic             tick
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, CHECK = 2'd2;
  localparam logic [IDX_W-1:0] VRANK = (MODE != 0) ? IDX_W'(N_CH - 1) : '0;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0] st_q, st_d;
  logic [N_CH-1:0] btn_q, btn_d, occ_q, occ_d;
  logic clr_q, clr_d, ev_q, ev_d;
  logic [IDX_W-1:0] evi_q, evi_d, c, v;
  logic [IDX_W-1:0] rank_q [N_CH];
  logic [IDX_W-1:0] rank_d [N_CH];
  assign tick = cnt_q == CNT_W'(TICK_DIV - 1);
  assign led_free = ~occ_q;
  assign evict_valid = ev_q;
  assign evict_idx = evi_q;
  always_comb begin
    c = '0;
    v = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (btn_q[i]) c = IDX_W'(i);
      if (occ_q[i] && rank_q[i] == VRANK) v = IDX_W'(i);
    end
  end
  always_comb begin
    st_d = st_q;
    btn_d = btn_q;
    clr_d = clr_q;
    occ_d = occ_q;
    rank_d = rank_q;
    ev_d = 1'b0;
    evi_d = evi_q;
    if (st_q == IDLE) begin
      if (tick) begin
        btn_d = btn;
        clr_d = clr;
        st_d = ACCESS;
      end
    end else if (st_q == ACCESS) begin
      st_d = CHECK;
      if (clr_q) begin
        occ_d = '0;
        rank_d = '{default: '0};
        st_d = IDLE;
      end else if (|btn_q) begin
        // channels more recent than the hit (or all, on a miss) age by one
        for (int i = 0; i < N_CH; i++)
          if (occ_q[i] && (!occ_q[c] || rank_q[i] < rank_q[c])) rank_d[i] = rank_q[i] + 1'b1;
        rank_d[c] = '0;
        occ_d[c] = 1'b1;
      end
    end else begin
      st_d = IDLE;
      if (&occ_q) begin
        for (int i = 0; i < N_CH; i++)
          if (occ_q[i] && rank_q[i] > rank_q[v]) rank_d[i] = rank_q[i] - 1'b1;
        occ_d[v] = 1'b0;
        rank_d[v] = '0;
        ev_d = 1'b1;
        evi_d = v;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      st_q <= IDLE;
      btn_q <= '0;
      clr_q <= 1'b0;
      occ_q <= '0;
      rank_q <= '{default: '0};
      ev_q <= 1'b0;
      evi_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      st_q <= st_d;
      btn_q <= btn_d;
      clr_q <= clr_d;
      occ_q <= occ_d;
      rank_q <= rank_d;
      ev_q <= ev_d;
      evi_q <= evi_d;
    end
  end
  always_comb begin
    occ_count = '0;
    for (int i = 0; i < N_CH; i++) occ_count = occ_count + (IDX_W + 1)'(occ_q[i]);
  end
  always_comb begin
    mru_idx = '0;
    lru_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (occ_q[i] && rank_q[i] == '0) mru_idx = IDX_W'(i);
      if (occ_q[i] && {1'b0, rank_q[i]} == occ_count - 1'b1) lru_idx = IDX_W'(i);
    end
  end
endmodule

// File: doc/mru_tracker.md
Name: mru_tracker

Overview:
- Parametrised most-recently-used slot tracker for N_CH user buttons.
- On a prescaled tick it samples the buttons and marks the pressed channel as most recent, using a rank-based recency order with no timestamps and no wrap-around.
- When every channel is occupied, it evicts one channel according to MODE: most-recent (MODE=0) or least-recent (MODE=1).
- Drives per-channel "free" LEDs and status outputs; it sits between the debounced board buttons and the LED bank.

Parameters:
- N_CH, 5, number of channels/buttons (>=2)
- TICK_DIV, 100000000, clk cycles per sampling tick (>=3)
- MODE, 0, eviction policy: 0 = evict MRU, 1 = evict LRU
- IDX_W, $clog2(N_CH), channel index width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- btn  in  N_CH  button levels, sampled only on tick
- clr  in  1  user clear, sampled only on tick
- led_free  out  N_CH  1 = channel unoccupied
- occ_count  out  IDX_W+1  number of occupied channels
- mru_idx  out  IDX_W  channel with rank 0 (valid when occ_count>0, else 0)
- lru_idx  out  IDX_W  channel with rank occ_count-1 (valid when occ_count>0, else 0)
- evict_valid  out  1  one-cycle pulse when an eviction occurs
- evict_idx  out  IDX_W  evicted channel; holds its last value otherwise
- tick  out  1  prescaler tick strobe (for debug/bench)

Behaviour:
- Reset values:
  - prescaler cnt=0, FSM=IDLE
  - occ=0 and all ranks=0
  - led_free=all 1s
  - occ_count=0, mru_idx=0, lru_idx=0
  - evict_valid=0, evict_idx=0, tick=0
- Reset timing:
  - rst overrides everything in any state, including mid-ACCESS/CHECK.
  - The cleared state is visible on outputs in the cycle after the reset edge.
- Prescaler:
  - cnt increments each clk.
  - When cnt==TICK_DIV-1: tick=1 for that cycle, then cnt returns to 0.
- FSM states: IDLE, ACCESS, CHECK.
- IDLE:
  - On tick: latch btn into btn_q and clr into clr_q.
  - Go to ACCESS.
- ACCESS:
  - If clr_q: clear all occ and ranks, go to IDLE. No eviction; btn_q is ignored.
  - Else if btn_q!=0: c = lowest set index of btn_q (fixed priority; other presses are dropped).
    - If c is occupied with rank r: every occupied channel with rank<r gets rank+1; c gets rank 0.
    - If c is free: every occupied channel gets rank+1; c is set occupied with rank 0.
  - Go to CHECK. (btn_q==0 also goes to CHECK.)
- CHECK:
  - If all N_CH are occupied, select victim v:
    - MODE=0: v = channel with rank 0.
    - MODE=1: v = channel with rank N_CH-1.
  - Then: clear occ[v]; every occupied channel with rank>rank(v) gets rank-1.
  - evict_valid=1 and evict_idx=v, registered (visible the cycle after CHECK).
  - Go to IDLE.
- Invariant: the ranks of occupied channels are always exactly 0..occ_count-1 with no duplicates. Free-channel ranks are 0 and never observed.
- Outputs:
  - Status outputs are registered from state and reflect each update one cycle later.
  - led_free = ~occ.
- Latency: a press sampled at tick is reflected on outputs 2 cycles after the tick cycle. An eviction is reflected 3 cycles after it.
- Sequencing: TICK_DIV>=3 guarantees IDLE is re-entered before the next tick. A tick arriving outside IDLE is impossible by construction.
- Full transient: occ_count may equal N_CH for one cycle only (between ACCESS and CHECK). After CHECK, occ_count<=N_CH-1.

Test Plan:
- rst asserted mid-run, released -> led_free=5'b11111, occ_count=0, evict_valid=0; tick period is exactly 4 clks (bench uses N_CH=5, TICK_DIV=4).
- Press btn0, btn1, btn2, btn3 on successive ticks -> led_free=5'b10000, occ_count=4, mru_idx=3, lru_idx=0, no evict_valid.
- MODE=0, continuing, press btn4 -> occ_count briefly 5, then a single evict_valid pulse with evict_idx=4; led_free=5'b10000, mru_idx=3.
- MODE=1, same sequence -> evict_idx=0, led_free=5'b00001, mru_idx=4, lru_idx=1.
- From state {0,1,2 occupied, mru=2}, apply btn=5'b10110 -> only ch1 updated: mru_idx=1, lru_idx=0, occ_count=3. Then press btn0 -> mru_idx=0, lru_idx=2, occ_count unchanged.
- clr=1 with btn=5'b00001 on the same tick -> all free, occ_count=0, no evict_valid. rst asserted during ACCESS -> reset state, and the latched press is lost.
